// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and small helpers.
package cnn_pkg;

  localparam int unsigned PIX_W = 8;

  function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one row of horizontal pair maxima.
// One synchronous write port and one asynchronous read port.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // No reset: every entry is rewritten in an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pooling over a raster-order pixel stream.
// Even rows park pair maxima in a line buffer; odd rows finish the window.
module maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  output logic             frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned AW    = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;

  logic             col_last, row_last;
  logic             lb_we;
  logic [AW-1:0]    lb_addr;
  logic [PIX_W-1:0] lb_wdata, lb_rdata, win_max;

  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign lb_addr  = AW'(col_q >> 1);
  assign lb_wdata = pix_max(hold_q, in_data);
  assign win_max  = pix_max(pix_max(lb_rdata, hold_q), in_data);
  assign lb_we    = in_valid && !rst && col_q[0] && !row_q[0];

  pool_line_buf #(
    .DEPTH  (IMG_W / 2),
    .ADDR_W (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    if (in_valid) begin
      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (row_q[0]) begin
        out_valid_d  = 1'b1;
        out_data_d   = win_max;
        frame_done_d = row_last && col_last;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Self-checking bench for maxpool_2x2 (4x4 frames) against a frame-array reference model.
module tb_maxpool_2x2;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       frame_done;

  maxpool_2x2 #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pixels placed into a frame array by raster index;
  // a window's max is taken from the four array cells once its last pixel lands.
  logic [7:0] pix [H][W];
  int         idx = 0;
  logic       exp_v = 1'b0;
  logic [7:0] exp_d = 8'd0;
  logic       exp_fd = 1'b0;
  int         exp_frames = 0;
  int         obs_frames = 0;
  int         exp_outs = 0;
  int         obs_outs = 0;

  function automatic logic [7:0] max4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle, advance the model at the edge, then compare on the falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    int rr, cc;
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    if (r) begin
      idx   = 0;
      exp_d = 8'd0;
    end else if (v) begin
      rr = idx / W;
      cc = idx % W;
      pix[rr][cc] = d;
      if ((rr % 2 == 1) && (cc % 2 == 1)) begin
        exp_v  = 1'b1;
        exp_d  = max4(pix[rr-1][cc-1], pix[rr-1][cc], pix[rr][cc-1], pix[rr][cc]);
        exp_fd = (idx == W * H - 1);
        exp_outs++;
        if (exp_fd) exp_frames++;
      end
      idx = (idx + 1) % (W * H);
    end
    @(negedge clk);
    if (out_valid === 1'b1) obs_outs++;
    if (frame_done === 1'b1) obs_frames++;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    check("out_data", {24'd0, out_data}, {24'd0, exp_d});
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
  endtask

  task automatic ramp(input logic rev);
    for (int i = 0; i < W * H; i++) step(1'b1, rev ? 8'(W * H - 1 - i) : 8'(i), 1'b0);
  endtask

  initial begin
    // Reset state, with in_valid high to confirm it is ignored during reset.
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'h77, 1'b1);

    ramp(1'b0);                              // 5, 7, 13, 15
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    ramp(1'b1);                              // 15, 13, 7, 5

    for (int i = 0; i < W * H; i++)          // single 255 at (row 1, col 0)
      step(1'b1, (i == W) ? 8'd255 : 8'd0, 1'b0);

    for (int i = 0; i < W * H; i++) begin    // gaps after every second pixel
      step(1'b1, 8'(i), 1'b0);
      if (i % 2 == 1) repeat (3) step(1'b0, 8'hAA, 1'b0);
    end

    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    step(1'b1, 8'hEE, 1'b1);                 // mid-frame reset
    ramp(1'b0);

    ramp(1'b0);                              // two back-to-back frames
    ramp(1'b0);

    for (int f = 0; f < 3; f++) begin        // random data, random gaps
      for (int i = 0; i < W * H; i++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
        step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      end
    end
    for (int i = 0; i < W * H; i++) step(1'b1, ($urandom_range(0, 1) == 1) ? 8'd0 : 8'd255, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0);

    check("output_count", 32'(obs_outs), 32'(exp_outs));
    check("frame_done_count", 32'(obs_frames), 32'(exp_frames));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
